dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port, synchronous-read 16-bit data memory between the single-cycle core's load/store path and an external loader/debug port. Core requests come straight from the decoded `mem_read`/`mem_write` strobes; the block stalls the core until its access completes. It round-robins against the external port so neither requester starves, and keeps a stall-cycle counter for performance checks.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 16, memory data width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_mem_read`  in  1  core load strobe (level, held while stalled)
- `cpu_mem_write`  in  1  core store strobe (level, held while stalled)
- `cpu_addr`  in  ADDR_W  core address
- `cpu_wdata`  in  DATA_W  core store data
- `cpu_rdata`  out  DATA_W  load data, valid when `cpu_stall`=0 in the return cycle
- `cpu_stall`  out  1  freeze core PC/regfile this cycle
- `ext_req`  in  1  external request; addr/we/wdata stable until granted
- `ext_we`  in  1  1 = write, 0 = read
- `ext_addr`  in  ADDR_W  external address
- `ext_wdata`  in  DATA_W  external write data
- `ext_gnt`  out  1  one-cycle pulse in the issue cycle
- `ext_rvalid`  out  1  one-cycle pulse: `ext_rdata` valid
- `ext_rdata`  out  DATA_W  external read data
- `mem_en`, `mem_we`  out  1  memory port enable / write enable
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W
- `mem_rdata`  in  DATA_W  valid the cycle after a read issue
- `protocol_err`  out  1  sticky: `cpu_mem_read` & `cpu_mem_write` seen together
- `stall_cnt`  out  16  saturating count of cycles with `cpu_stall`=1

## Operation
- States: IDLE, CPU_RD, EXT_RD. Port issues at most one access per cycle, only in IDLE.
- IDLE: cpu_req = `cpu_mem_read`|`cpu_mem_write`. Single requester wins. Both: winner is the requester not granted last (`last_gnt` bit).
- CPU store granted: `mem_en`=`mem_we`=1 that cycle, `cpu_stall`=0, stay IDLE.
- CPU load granted: `mem_en`=1, `mem_we`=0, `cpu_stall`=1, go CPU_RD.
- CPU_RD: no issue; `cpu_rdata`=`mem_rdata`, `cpu_stall`=0, core request inputs ignored (same instruction); go IDLE.
- CPU request not granted: `cpu_stall`=1.
- Ext write granted: `ext_gnt`=1, memory written, stay IDLE. Ext read granted: `ext_gnt`=1, go EXT_RD.
- EXT_RD: no issue; `ext_rvalid`=1, `ext_rdata`=`mem_rdata`; `cpu_stall`=1 if cpu_req; go IDLE.
- Read and write both asserted by core: treat as store, set `protocol_err` (cleared only by reset).
- `last_gnt` updates on every grant. Reset value = EXT, so the core wins the first contest.
- `stall_cnt` increments each stalled cycle and saturates at 16'hFFFF.

## Timing
- Reset (async assert, sync release): state IDLE; `last_gnt`=EXT; `stall_cnt`=0; `protocol_err`=0.
- While `rst_n`=0, all outputs are 0.
- Uncontested core store: 0 stall cycles. Uncontested core load: 1 stall cycle, data at writeback edge of cycle N+1.
- Worst-case core load under contention: 3 stall cycles (one ext read, then its own).
- Ext read latency: grant cycle + 1 → `ext_rvalid`. The ext master can present a new request in the `ext_rvalid` cycle; that request is considered from the next IDLE cycle.
- Memory outputs are combinational from state and the winning request. Port is idle (`mem_en`=0) in CPU_RD and EXT_RD.
- Reset mid-CPU_RD/EXT_RD: transaction is dropped, no `ext_rvalid` after release.

## Structure
- Shared package `dmem_pkg`: state enum {IDLE, CPU_RD, EXT_RD}, grant encoding {GNT_CPU, GNT_EXT}, `ADDR_W`/`DATA_W` defaults.
- One sub-module `rr_pick2`: 2-requester round-robin with registered `last_gnt`. FSM, muxing and counter stay in `dmem_arbiter`.

## Test plan
- Reset, then core store addr 0x0010 data 0xBEEF, no ext → `mem_we`=1 same cycle, `cpu_stall` never 1, `stall_cnt`=0.
- Core load 0x0010 after the store → `cpu_stall`=1 for exactly 1 cycle, `cpu_rdata`=0xBEEF in the CPU_RD cycle, `stall_cnt`=1.
- Core load and ext read of 0x0020 (=0x1234) requested simultaneously from reset → core granted first. Ext granted in the cycle after CPU_RD, `ext_rvalid`/0x1234 one cycle later. A second contest goes to whichever was not last granted.
- Continuous `ext_req` reads plus back-to-back core loads → grants alternate; no requester waits more than 3 cycles.
- `cpu_mem_read`=`cpu_mem_write`=1 → store performed, `protocol_err`=1 and held until reset.
- Assert `rst_n`=0 during EXT_RD → all outputs 0 immediately; after release, no `ext_rvalid`; next contest goes to the core.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DmemAddrW  = 16;
  localparam int unsigned DmemDataW  = 16;
  localparam int unsigned StallCntW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCpuRd,
    StExtRd
  } dmem_state_e;

  typedef enum logic {
    GntCpu,
    GntExt
  } dmem_gnt_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, external-port and memory-port signals of the data-memory arbiter.
// master: requesters plus the memory macro; slave: the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, ext_gnt, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, ext_gnt, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker. A lone requester always wins; on a tie the
// requester that was not granted last wins. The core wins the first tie after reset.
module rr_pick2
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_cpu,
  input  logic req_ext,
  output logic gnt_cpu,
  output logic gnt_ext
);

  dmem_gnt_e last_gnt_q;

  // Grant decision; nothing is granted while the shared port is busy returning data.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_ext = 1'b0;
    if (en) begin
      if (req_cpu && req_ext) begin
        gnt_cpu = (last_gnt_q == GntExt);
        gnt_ext = (last_gnt_q == GntCpu);
      end else begin
        gnt_cpu = req_cpu;
        gnt_ext = req_ext;
      end
    end
  end

  // Remember the most recent winner on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= GntExt;
    end else if (gnt_cpu) begin
      last_gnt_q <= GntCpu;
    end else if (gnt_ext) begin
      last_gnt_q <= GntExt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous-read data memory between the core load/store
// path and an external loader/debug port. Stalls the core until its access is done.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DmemAddrW,
  parameter int unsigned DATA_W = DmemDataW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_arbiter_if.slave        bus,
  output logic                 protocol_err,
  output logic [StallCntW-1:0] stall_cnt
);

  dmem_state_e          state_q, state_d;
  logic                 cpu_req, cpu_wr, in_idle;
  logic                 gnt_cpu, gnt_ext;
  logic                 stall;
  logic                 protocol_err_q;
  logic [StallCntW-1:0] stall_cnt_q;

  assign cpu_req = bus.cpu_mem_read | bus.cpu_mem_write;
  // Both strobes together are treated as a store.
  assign cpu_wr  = bus.cpu_mem_write;
  assign in_idle = (state_q == StIdle);

  rr_pick2 u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (in_idle),
    .req_cpu (cpu_req),
    .req_ext (bus.ext_req),
    .gnt_cpu (gnt_cpu),
    .gnt_ext (gnt_ext)
  );

  // Next state: reads spend one extra cycle returning data with the port idle.
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle: begin
        if (gnt_cpu && !cpu_wr) begin
          state_d = StCpuRd;
        end else if (gnt_ext && !bus.ext_we) begin
          state_d = StExtRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Core stall: only a granted store or the load return cycle lets the core advance.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      StIdle:  stall = cpu_req & ~(gnt_cpu & cpu_wr);
      StExtRd: stall = cpu_req;
      default: stall = 1'b0;
    endcase
  end

  // Outputs are combinational and forced to zero while reset is held.
  always_comb begin
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = {ADDR_W{1'b0}};
    bus.mem_wdata  = {DATA_W{1'b0}};
    bus.cpu_rdata  = {DATA_W{1'b0}};
    bus.cpu_stall  = 1'b0;
    bus.ext_gnt    = 1'b0;
    bus.ext_rvalid = 1'b0;
    bus.ext_rdata  = {DATA_W{1'b0}};
    if (rst_n) begin
      if (gnt_cpu) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = cpu_wr;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end else if (gnt_ext) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.ext_we;
        bus.mem_addr  = bus.ext_addr;
        bus.mem_wdata = bus.ext_wdata;
      end
      bus.cpu_stall = stall;
      bus.ext_gnt   = gnt_ext;
      if (state_q == StCpuRd) begin
        bus.cpu_rdata = bus.mem_rdata;
      end
      if (state_q == StExtRd) begin
        bus.ext_rvalid = 1'b1;
        bus.ext_rdata  = bus.mem_rdata;
      end
    end
  end

  // State, sticky protocol error and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      protocol_err_q <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (bus.cpu_mem_read && bus.cpu_mem_write) begin
        protocol_err_q <= 1'b1;
      end
      if (stall && (stall_cnt_q != {StallCntW{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign protocol_err = protocol_err_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level reference model and a golden memory image.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        protocol_err;
  logic [15:0] stall_cnt;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .protocol_err (protocol_err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Memory macro: synchronous read, data valid the cycle after issue.
  logic [15:0] sram [0:65535];
  logic [15:0] sram_rdata = 16'h0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            sram_rdata <= sram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: golden memory, who has read data due next cycle, tie preference.
  logic [15:0] ref_mem [0:65535];
  int          ret_kind;     // 0 none, 1 core load data due, 2 ext load data due
  logic [15:0] ret_addr;
  bit          cpu_first;
  int          exp_stalls;
  bit          exp_perr;
  bit          m_core_done;
  bit          m_ext_go;

  task automatic model_reset();
    ret_kind   = 0;
    cpu_first  = 1'b1;
    exp_stalls = 0;
    exp_perr   = 1'b0;
  endtask

  task automatic model_check();
    bit creq, cw, cpu_go, ext_go;
    logic e_en, e_we, e_stall, e_gnt, e_rv;
    logic [15:0] e_addr, e_wd;
    creq = bus.cpu_mem_read | bus.cpu_mem_write;
    cw   = bus.cpu_mem_write;
    cpu_go = 0; ext_go = 0;
    e_en = 0; e_we = 0; e_stall = 0; e_gnt = 0; e_rv = 0; e_addr = 0; e_wd = 0;
    if (ret_kind == 1) begin
      check_eq("cpu_rdata", bus.cpu_rdata, ref_mem[ret_addr]);
    end else if (ret_kind == 2) begin
      e_rv = 1; e_stall = creq;
      check_eq("ext_rdata", bus.ext_rdata, ref_mem[ret_addr]);
    end else begin
      cpu_go  = creq && (!bus.ext_req || cpu_first);
      ext_go  = bus.ext_req && !cpu_go;
      e_stall = creq && !(cpu_go && cw);
      e_gnt   = ext_go;
      if (cpu_go) begin
        e_en = 1; e_we = cw; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata;
      end else if (ext_go) begin
        e_en = 1; e_we = bus.ext_we; e_addr = bus.ext_addr; e_wd = bus.ext_wdata;
      end
    end
    check_eq("cpu_stall", bus.cpu_stall, e_stall);
    check_eq("ext_gnt", bus.ext_gnt, e_gnt);
    check_eq("ext_rvalid", bus.ext_rvalid, e_rv);
    check_eq("mem_en", bus.mem_en, e_en);
    if (e_en) begin
      check_eq("mem_we", bus.mem_we, e_we);
      check_eq("mem_addr", bus.mem_addr, e_addr);
      if (e_we) check_eq("mem_wdata", bus.mem_wdata, e_wd);
    end
    check_eq("stall_cnt", stall_cnt, exp_stalls);
    check_eq("protocol_err", protocol_err, exp_perr);
    // Advance the model past this cycle's clock edge.
    if (e_stall && exp_stalls < 65535) exp_stalls++;
    if (bus.cpu_mem_read && bus.cpu_mem_write) exp_perr = 1'b1;
    m_core_done = creq && !e_stall;
    m_ext_go    = ext_go;
    ret_kind = 0;
    if (cpu_go && !cw) begin
      ret_kind = 1; ret_addr = bus.cpu_addr;
    end else if (ext_go && !bus.ext_we) begin
      ret_kind = 2; ret_addr = bus.ext_addr;
    end
    if (cpu_go) cpu_first = 1'b0;
    if (ext_go) cpu_first = 1'b1;
    if (e_en && e_we) ref_mem[e_addr] = e_wd;
  endtask

  // Inputs change at negedge; outputs are checked 2 time units later, before posedge.
  task automatic settle();
    #2;
    model_check();
  endtask

  task automatic advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.cpu_mem_read = 0; bus.cpu_mem_write = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_a"}, {bus.cpu_rdata, bus.cpu_stall, bus.ext_gnt, bus.ext_rvalid,
                           bus.ext_rdata, bus.mem_en, bus.mem_we}, 64'h0);
    check_eq({tag, "_b"}, {bus.mem_addr, bus.mem_wdata, protocol_err, stall_cnt}, 64'h0);
  endtask

  // Assert reset at a negedge, hold two cycles, release at a negedge.
  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // Randomized drivers: core instructions hold until done, ext requests until granted.
  int          core_wait, ext_wait;
  logic        nx_rd, nx_wr, nx_ereq, nx_ewe;
  logic [15:0] nx_caddr, nx_cwd, nx_eaddr, nx_ewd;

  task automatic plan_next(input int ext_pct, input bit loads_only);
    bit creq;
    int r;
    creq = bus.cpu_mem_read | bus.cpu_mem_write;
    if (bus.cpu_stall) core_wait++;
    if (bus.ext_req && !bus.ext_gnt) ext_wait++;
    nx_rd = bus.cpu_mem_read; nx_wr = bus.cpu_mem_write;
    nx_caddr = bus.cpu_addr; nx_cwd = bus.cpu_wdata;
    nx_ereq = bus.ext_req; nx_ewe = bus.ext_we;
    nx_eaddr = bus.ext_addr; nx_ewd = bus.ext_wdata;
    if (!creq || m_core_done) begin
      if (creq) check_eq("core_wait_max3", core_wait <= 3, 1);
      core_wait = 0;
      r = loads_only ? 1 : $urandom_range(0, 3);
      nx_rd = (r == 1) || (r == 2);
      nx_wr = (r == 3);
      nx_caddr = 16'h0100 + 16'($urandom_range(0, 15));
      nx_cwd = 16'($urandom);
    end
    if (!bus.ext_req || m_ext_go) begin
      if (bus.ext_req) check_eq("ext_wait_max3", ext_wait <= 3, 1);
      ext_wait = 0;
      nx_ereq = $urandom_range(0, 99) < ext_pct;
      nx_ewe = loads_only ? 1'b0 : 1'($urandom_range(0, 1));
      nx_eaddr = 16'h0100 + 16'($urandom_range(0, 15));
      nx_ewd = 16'($urandom);
    end
  endtask

  task automatic apply_next();
    bus.cpu_mem_read = nx_rd; bus.cpu_mem_write = nx_wr;
    bus.cpu_addr = nx_caddr; bus.cpu_wdata = nx_cwd;
    bus.ext_req = nx_ereq; bus.ext_we = nx_ewe;
    bus.ext_addr = nx_eaddr; bus.ext_wdata = nx_ewd;
  endtask

  task automatic run_random(input int cycles, input int ext_pct, input bit loads_only);
    core_wait = 0; ext_wait = 0;
    for (int c = 0; c < cycles; c++) begin
      settle();
      plan_next(ext_pct, loads_only);
      advance();
      apply_next();
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = 16'($urandom);
      sram[i] = ref_mem[i];
    end
    ref_mem[16'h0020] = 16'h1234;
    sram[16'h0020] = 16'h1234;
    model_reset();
    m_core_done = 0; m_ext_go = 0;

    // Reset with requests pending: every output must read zero.
    clear_inputs();
    bus.cpu_mem_read = 1; bus.ext_req = 1;
    #1 rst_n = 0;
    #1 check_outputs_zero("reset_outputs");
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;

    // Uncontested store: written in the same cycle, no stall.
    bus.cpu_mem_write = 1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'hBEEF;
    settle();
    check_eq("store_we", bus.mem_we, 1);
    check_eq("store_stall", bus.cpu_stall, 0);
    advance();
    // Uncontested load: one stall cycle, data in the return cycle.
    bus.cpu_mem_write = 0; bus.cpu_mem_read = 1;
    settle();
    check_eq("load_stall1", bus.cpu_stall, 1);
    advance();
    settle();
    check_eq("load_rdata", bus.cpu_rdata, 16'hBEEF);
    check_eq("load_stall2", bus.cpu_stall, 0);
    advance();
    clear_inputs();
    settle();
    check_eq("load_stall_cnt", stall_cnt, 1);
    advance();

    // Contest from reset: core first, then ext wins the next tie.
    do_reset();
    bus.cpu_mem_read = 1; bus.cpu_addr = 16'h0020;
    bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 16'h0020;
    settle();
    check_eq("c1_ext_gnt", bus.ext_gnt, 0);
    check_eq("c1_mem_en", bus.mem_en, 1);
    advance();
    settle();
    check_eq("c1_cpu_rdata", bus.cpu_rdata, 16'h1234);
    advance();
    bus.cpu_addr = 16'h0010;
    settle();
    check_eq("c2_ext_gnt", bus.ext_gnt, 1);
    check_eq("c2_cpu_stall", bus.cpu_stall, 1);
    advance();
    bus.ext_req = 0;
    settle();
    check_eq("c2_ext_rvalid", bus.ext_rvalid, 1);
    check_eq("c2_ext_rdata", bus.ext_rdata, 16'h1234);
    advance();
    settle();
    check_eq("c3_cpu_addr", bus.mem_addr, 16'h0010);
    advance();
    settle();
    check_eq("c3_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
    advance();
    clear_inputs();
    settle();
    advance();

    // Both core strobes: store happens, error flag sticks.
    bus.cpu_mem_read = 1; bus.cpu_mem_write = 1;
    bus.cpu_addr = 16'h0030; bus.cpu_wdata = 16'h5A5A;
    settle();
    check_eq("perr_store_we", bus.mem_we, 1);
    advance();
    clear_inputs();
    settle();
    check_eq("perr_set", protocol_err, 1);
    advance();
    bus.cpu_mem_read = 1; bus.cpu_addr = 16'h0030;
    settle();
    advance();
    settle();
    check_eq("perr_load_back", bus.cpu_rdata, 16'h5A5A);
    advance();
    clear_inputs();
    run_random(40, 50, 0);
    clear_inputs();
    settle();
    check_eq("perr_held", protocol_err, 1);
    advance();
    settle();
    advance();
    settle();
    advance();

    // Reset during EXT_RD: transaction dropped, core wins the next contest.
    clear_inputs();
    do_reset();
    bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 16'h0020;
    settle();
    check_eq("xr_gnt", bus.ext_gnt, 1);
    advance();
    bus.cpu_mem_read = 1; bus.cpu_addr = 16'h0010;
    #1 rst_n = 0;
    #1 check_outputs_zero("reset_in_ext_rd");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    settle();
    check_eq("xr_no_rvalid", bus.ext_rvalid, 0);
    check_eq("xr_core_first", bus.ext_gnt, 0);
    check_eq("xr_perr_clr", protocol_err, 0);
    advance();
    settle();
    advance();
    bus.cpu_mem_read = 0;
    settle();
    advance();
    bus.ext_req = 0;
    settle();
    advance();
    clear_inputs();
    settle();
    advance();

    // Randomized mixed traffic, then saturating ext reads against back-to-back loads.
    run_random(2000, 40, 0);
    run_random(600, 100, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
